// File: rtl/mem_arbiter_if.sv
// WISHBONE_IF: single-transfer memory bus shared by the arbiter's requesters
// and the memory side. width encodes the access size:
//   2'd0 = eDW_B (byte), 2'd1 = eDW_H (half-word), 2'd2 = eDW_W (word).
interface WISHBONE_IF;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] addr;
   logic [1:0]  width;
   logic [31:0] data_write;
   logic [31:0] data_read;
   logic        ack;

   // Bus initiator: drives the request, receives ack and read data
   modport master (
      output cyc, stb, we, addr, width, data_write,
      input  data_read, ack
   );

   // Bus target: receives the request, returns ack and read data
   modport slave (
      input  cyc, stb, we, addr, width, data_write,
      output data_read, ack
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (imem = requester 0, dmem = requester 1)
// in front of one shared memory bus. One transfer per grant, with an IDLE
// cycle between grants. A grant held TIMEOUT_CYCLES cycles without ack is
// force-released with a zero-data ack and a one-cycle oTimeout pulse.
// Build option MEM_ARB_RR_EN: ties go to the requester not granted last
// (round robin); without it, ties always go to dmem.
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic         iClk,
   input  logic         iRst,
   WISHBONE_IF.slave    imem_wb,
   WISHBONE_IF.slave    dmem_wb,
   WISHBONE_IF.master   mem_wb,
   output logic [1:0]   oGrant,
   output logic         oTimeout
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_q;
   logic        req_i, req_d;
   logic        tie_to_d;
   logic        sel_d;
   logic        gnt_cyc;
   logic        timeout_hit;

   assign req_i = imem_wb.cyc & imem_wb.stb;
   assign req_d = dmem_wb.cyc & dmem_wb.stb;

`ifdef MEM_ARB_RR_EN
   logic last_d_q;

   // Remember who won the latest grant so the next tie goes to the other side
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)
         last_d_q <= 1'b1;
      else if (state_q == IDLE && state_d != IDLE)
         last_d_q <= (state_d == GNT_D);
   end

   assign tie_to_d = ~last_d_q;
`else
   assign tie_to_d = 1'b1;
`endif

   // State register; reset drops the bus immediately by returning to IDLE
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Wait counter: zero on the first grant cycle, counts cycles without ack
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)
         wait_q <= 8'd0;
      else if (state_q == IDLE)
         wait_q <= 8'd0;
      else if (!mem_wb.ack)
         wait_q <= wait_q + 8'd1;
   end

   // Grant output is a flopped decode of the state being entered
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)
         oGrant <= 2'b00;
      else begin
         case (state_d)
            GNT_I:   oGrant <= 2'b01;
            GNT_D:   oGrant <= 2'b10;
            default: oGrant <= 2'b00;
         endcase
      end
   end

   // Next-state decode plus combinational routing between granted side and bus
   always_comb begin
      state_d            = state_q;
      sel_d              = (state_q == GNT_D);
      gnt_cyc            = 1'b0;
      timeout_hit        = 1'b0;
      mem_wb.cyc         = 1'b0;
      mem_wb.stb         = 1'b0;
      mem_wb.we          = 1'b0;
      mem_wb.addr        = 32'h0;
      mem_wb.width       = 2'd0;
      mem_wb.data_write  = 32'h0;
      imem_wb.ack        = 1'b0;
      imem_wb.data_read  = 32'h0;
      dmem_wb.ack        = 1'b0;
      dmem_wb.data_read  = 32'h0;

      if (state_q == IDLE) begin
         if (req_i && req_d)
            state_d = tie_to_d ? GNT_D : GNT_I;
         else if (req_d)
            state_d = GNT_D;
         else if (req_i)
            state_d = GNT_I;
      end else begin
         gnt_cyc           = sel_d ? dmem_wb.cyc        : imem_wb.cyc;
         mem_wb.cyc        = gnt_cyc;
         mem_wb.stb        = sel_d ? dmem_wb.stb        : imem_wb.stb;
         mem_wb.we         = sel_d ? dmem_wb.we         : imem_wb.we;
         mem_wb.addr       = sel_d ? dmem_wb.addr       : imem_wb.addr;
         mem_wb.width      = sel_d ? dmem_wb.width      : imem_wb.width;
         mem_wb.data_write = sel_d ? dmem_wb.data_write : imem_wb.data_write;

         // A real ack on the limit cycle wins over the forced release
         timeout_hit = gnt_cyc && !mem_wb.ack && (wait_q == WAIT_LIMIT);

         if (sel_d) begin
            dmem_wb.ack       = mem_wb.ack | timeout_hit;
            dmem_wb.data_read = timeout_hit ? 32'h0 : mem_wb.data_read;
         end else begin
            imem_wb.ack       = mem_wb.ack | timeout_hit;
            imem_wb.data_read = timeout_hit ? 32'h0 : mem_wb.data_read;
         end

         if (!gnt_cyc || mem_wb.ack || timeout_hit)
            state_d = IDLE;
      end
   end

   assign oTimeout = timeout_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with a scoreboard.
// Stimulus pushes the expected requester response; a negedge monitor pops it
// whenever a requester ack appears. A small memory model acks after a
// programmable number of bus cycles (0 = never).
module tb_mem_arbiter;

   typedef struct {
      logic [1:0]  acks;   // {dmem ack, imem ack}
      logic [31:0] data;
      logic        to;
      logic [1:0]  gnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  grant;
   logic        tmo;
   logic [7:0]  ack_delay;
   logic [31:0] rdata;
   logic [7:0]  bus_cnt;
   exp_t        exp_q[$];
   int          checks;
   int          failures;
   int          n;

   WISHBONE_IF imem_if();
   WISHBONE_IF dmem_if();
   WISHBONE_IF mem_if();

   mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .iClk     (clk),
      .iRst     (rst),
      .imem_wb  (imem_if),
      .dmem_wb  (dmem_if),
      .mem_wb   (mem_if),
      .oGrant   (grant),
      .oTimeout (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: count consecutive bus cycles, ack on the programmed one
   always @(posedge clk or posedge rst) begin
      if (rst)
         bus_cnt <= 8'd0;
      else if (mem_if.cyc)
         bus_cnt <= bus_cnt + 8'd1;
      else
         bus_cnt <= 8'd0;
   end

   assign mem_if.ack = mem_if.cyc & mem_if.stb & (ack_delay != 8'd0) &
                       (bus_cnt == ack_delay - 8'd1);
   assign mem_if.data_read = rdata;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endfunction

   function automatic void push(logic [1:0] acks, logic [31:0] data, logic to, logic [1:0] gnt);
      exp_t e;
      e.acks = acks; e.data = data; e.to = to; e.gnt = gnt;
      exp_q.push_back(e);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for the requester ack; n counts grant cycles starting at 1
   task automatic wait_ack(input int port, input int max, output int cnt);
      cnt = 1;
      while (!(port == 1 ? dmem_if.ack : imem_if.ack) && cnt < max) begin
         step();
         cnt++;
      end
      chk("ack_seen", 32'(port == 1 ? dmem_if.ack : imem_if.ack), 32'd1);
   endtask

   // Monitor: every requester ack must match the next scoreboard entry
   always @(negedge clk) begin
      exp_t e;
      if (imem_if.ack || dmem_if.ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack got=%b want=none", {dmem_if.ack, imem_if.ack});
         end else begin
            e = exp_q.pop_front();
            chk("ack_port", 32'({dmem_if.ack, imem_if.ack}), 32'(e.acks));
            chk("ack_data", dmem_if.ack ? dmem_if.data_read : imem_if.data_read, e.data);
            chk("ack_timeout", 32'(tmo), 32'(e.to));
            chk("ack_grant", 32'(grant), 32'(e.gnt));
            chk("other_data", dmem_if.ack ? imem_if.data_read : dmem_if.data_read, 32'h0);
         end
      end else if (tmo) begin
         checks++;
         failures++;
         $display("FAIL stray_timeout got=1 want=0");
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; n = 0;
      rst = 1'b1; ack_delay = 8'd0; rdata = 32'h0;
      imem_if.cyc = 0; imem_if.stb = 0; imem_if.we = 0; imem_if.addr = 0;
      imem_if.width = 2'd2; imem_if.data_write = 0;
      dmem_if.cyc = 0; dmem_if.stb = 0; dmem_if.we = 0; dmem_if.addr = 0;
      dmem_if.width = 2'd2; dmem_if.data_write = 0;

      // Reset state
      #12;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_timeout", 32'(tmo), 32'd0);
      chk("rst_cyc", 32'(mem_if.cyc), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single dmem load, memory acks on the 2nd bus cycle
      step();
      ack_delay = 8'd2; rdata = 32'hDEADBEEF;
      push(2'b10, 32'hDEADBEEF, 1'b0, 2'b10);
      dmem_if.cyc = 1; dmem_if.stb = 1; dmem_if.we = 0; dmem_if.addr = 32'h100;
      step();
      chk("load_grant", 32'(grant), 32'h2);
      chk("load_addr", mem_if.addr, 32'h100);
      chk("load_cyc", 32'(mem_if.cyc), 32'd1);
      chk("load_imem_ack", 32'(imem_if.ack), 32'd0);
      wait_ack(1, 40, n);
      chk("load_ack_cycle", 32'(n), 32'd2);
      step();
      chk("load_idle_grant", 32'(grant), 32'd0);
      chk("load_idle_cyc", 32'(mem_if.cyc), 32'd0);
      dmem_if.cyc = 0; dmem_if.stb = 0;

      // Both requesters held, memory acks on the first bus cycle
      step();
      ack_delay = 8'd1; rdata = 32'hA5A50001;
`ifdef MEM_ARB_RR_EN
      push(2'b01, 32'hA5A50001, 1'b0, 2'b01);
      push(2'b10, 32'hA5A50001, 1'b0, 2'b10);
      push(2'b01, 32'hA5A50001, 1'b0, 2'b01);
      push(2'b10, 32'hA5A50001, 1'b0, 2'b10);
`else
      for (int k = 0; k < 4; k++) push(2'b10, 32'hA5A50001, 1'b0, 2'b10);
`endif
      imem_if.cyc = 1; imem_if.stb = 1; imem_if.addr = 32'h200;
      dmem_if.cyc = 1; dmem_if.stb = 1; dmem_if.addr = 32'h300;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i % 2 == 1)
            chk("tie_idle_grant", 32'(grant), 32'd0);
         else
            chk("tie_busy_cyc", 32'(mem_if.cyc), 32'd1);
      end
      imem_if.cyc = 0; imem_if.stb = 0;
      dmem_if.cyc = 0; dmem_if.stb = 0;

      // Timeout: memory never acks, forced zero-data ack on the 16th cycle
      step();
      ack_delay = 8'd0; rdata = 32'hFFFFFFFF;
      push(2'b01, 32'h0, 1'b1, 2'b01);
      imem_if.cyc = 1; imem_if.stb = 1; imem_if.addr = 32'h40;
      step();
      wait_ack(0, 40, n);
      chk("to_ack_cycle", 32'(n), 32'd16);
      step();
      chk("to_cyc_after", 32'(mem_if.cyc), 32'd0);
      chk("to_grant_after", 32'(grant), 32'd0);
      imem_if.cyc = 0; imem_if.stb = 0;

      // Real ack exactly on the limit cycle is a normal ack
      step();
      ack_delay = 8'd16; rdata = 32'h12345678;
      push(2'b01, 32'h12345678, 1'b0, 2'b01);
      imem_if.cyc = 1; imem_if.stb = 1; imem_if.addr = 32'h44;
      step();
      wait_ack(0, 40, n);
      chk("lim_ack_cycle", 32'(n), 32'd16);
      step();
      chk("lim_cyc_after", 32'(mem_if.cyc), 32'd0);
      imem_if.cyc = 0; imem_if.stb = 0;

      // Reset pulse in the 3rd dmem grant cycle, away from any clock edge
      step();
      ack_delay = 8'd0;
      dmem_if.cyc = 1; dmem_if.stb = 1; dmem_if.we = 1;
      dmem_if.addr = 32'h500; dmem_if.data_write = 32'h0BADF00D;
      step();
      step();
      step();
      chk("rg_grant_before", 32'(grant), 32'h2);
      chk("rg_wdata_before", mem_if.data_write, 32'h0BADF00D);
      #2 rst = 1'b1;
      #1;
      chk("rg_cyc", 32'(mem_if.cyc), 32'd0);
      chk("rg_stb", 32'(mem_if.stb), 32'd0);
      chk("rg_grant", 32'(grant), 32'd0);
      chk("rg_dmem_ack", 32'(dmem_if.ack), 32'd0);
      chk("rg_imem_ack", 32'(imem_if.ack), 32'd0);
      ack_delay = 8'd1; rdata = 32'hCAFEF00D;
      push(2'b10, 32'hCAFEF00D, 1'b0, 2'b10);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_rst_grant", 32'(grant), 32'h2);
      step();
      dmem_if.cyc = 0; dmem_if.stb = 0; dmem_if.we = 0;

      repeat (3) step();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
